// File: rtl/dmux_deser_if.sv
// Bus bundle for the two-channel DMUX deserializer: serial strobed inputs
// and the per-channel valid/ready word outputs.
interface dmux_deser_if #(
   parameter int WIDTH = 8
);
   logic             in1_bit;
   logic             in1_vld;
   logic             in2_bit;
   logic             in2_vld;
   logic [WIDTH-1:0] out1_data;
   logic [WIDTH-1:0] out2_data;
   logic             out1_valid;
   logic             out2_valid;
   logic             out1_ready;
   logic             out2_ready;

   modport slave (
      input  in1_bit, in1_vld, in2_bit, in2_vld, out1_ready, out2_ready,
      output out1_data, out2_data, out1_valid, out2_valid
   );

   modport master (
      output in1_bit, in1_vld, in2_bit, in2_vld, out1_ready, out2_ready,
      input  out1_data, out2_data, out1_valid, out2_valid
   );
endinterface

// File: rtl/dmux_deser.sv
// Two independent LSB-first serial-to-parallel channels with a one-word holding
// register each. Define DMUX_DESER_PARITY_EN to append an even-parity bit per frame.
module dmux_deser #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   dmux_deser_if.slave   bus,
   output logic [1:0]    ovf,
   output logic [1:0]    perr
);
`ifdef DMUX_DESER_PARITY_EN
   localparam int FRAME = WIDTH + 1;

   function automatic logic calc_even_parity(input logic [WIDTH-1:0] payload);
      return ^payload;
   endfunction
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME + 1);

   logic [1:0]       bit_s;
   logic [1:0]       vld_s;
   logic [1:0]       rdy_s;
   logic [1:0]       valid_s;
   logic [1:0]       ovf_s;
   logic [1:0]       perr_s;
   logic [WIDTH-1:0] data_s [2];

   assign bit_s = {bus.in2_bit, bus.in1_bit};
   assign vld_s = {bus.in2_vld, bus.in1_vld};
   assign rdy_s = {bus.out2_ready, bus.out1_ready};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [WIDTH-1:0] sr_q, sr_d;
      logic [WIDTH-1:0] data_q, data_d;
      logic [WIDTH-1:0] word_s;
      logic             valid_q, valid_d;
      logic             ovf_q, ovf_d;
      logic             perr_q, perr_d;
      logic             done_s, good_s, xfer_s, load_s;

      // Bit assembly, parity check and holding-register next state.
      always_comb begin
         cnt_d   = cnt_q;
         sr_d    = sr_q;
         done_s  = vld_s[ch] && !clr && (cnt_q == CW'(FRAME - 1));
         xfer_s  = valid_q && rdy_s[ch];
`ifdef DMUX_DESER_PARITY_EN
         // The parity bit is compared, never shifted, so sr_q already holds the payload.
         word_s  = sr_q;
         good_s  = (bit_s[ch] == calc_even_parity(sr_q));
`else
         word_s  = {bit_s[ch], sr_q[WIDTH-1:1]};
         good_s  = 1'b1;
`endif
         if (clr) begin
            cnt_d = '0;
            sr_d  = '0;
         end else if (vld_s[ch]) begin
            if (done_s) begin
               cnt_d = '0;
               sr_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
               sr_d  = {bit_s[ch], sr_q[WIDTH-1:1]};
            end
         end else begin
            cnt_d = cnt_q;
            sr_d  = sr_q;
         end

         load_s  = done_s && good_s && (!valid_q || xfer_s);
         data_d  = load_s ? word_s : data_q;
         valid_d = load_s || (valid_q && !xfer_s);
         ovf_d   = ovf_q || (done_s && good_s && valid_q && !xfer_s);
         perr_d  = perr_q || (done_s && !good_s);
      end

      // Channel state registers; reset wins over clr, strobes and ready.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
         end
      end

      assign data_s[ch]  = data_q;
      assign valid_s[ch] = valid_q;
      assign ovf_s[ch]   = ovf_q;
      assign perr_s[ch]  = perr_q;
   end

   assign bus.out1_data  = data_s[0];
   assign bus.out2_data  = data_s[1];
   assign bus.out1_valid = valid_s[0];
   assign bus.out2_valid = valid_s[1];
   assign ovf            = ovf_s;
`ifdef DMUX_DESER_PARITY_EN
   assign perr           = perr_s;
`else
   assign perr           = 2'b00;
`endif
endmodule

// File: tb/tb_dmux_deser.sv
// Directed bench for dmux_deser (WIDTH=8); honours DMUX_DESER_PARITY_EN when defined.
module tb_dmux_deser;
`ifdef DMUX_DESER_PARITY_EN
   localparam int FR = 9;
`else
   localparam int FR = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic [1:0] ovf;
   logic [1:0] perr;
   int         tests = 0;
   int         fails = 0;

   dmux_deser_if #(.WIDTH(8)) bus ();

   dmux_deser #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus),
      .ovf   (ovf),
      .perr  (perr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] frame(input logic [7:0] w);
`ifdef DMUX_DESER_PARITY_EN
      return {7'd0, ^w, w};
`else
      return {8'd0, w};
`endif
   endfunction

   // One strobe per bit, LSB first, back to back.
   task automatic send_bits(input int ch, input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         if (ch == 1) begin
            bus.in1_vld = 1'b1;
            bus.in1_bit = v[i];
         end else begin
            bus.in2_vld = 1'b1;
            bus.in2_bit = v[i];
         end
         tick();
         bus.in1_vld = 1'b0;
         bus.in2_vld = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] f;
      rst_n = 1'b0;
      clr   = 1'b0;
      bus.in1_bit = 1'b0; bus.in1_vld = 1'b0;
      bus.in2_bit = 1'b0; bus.in2_vld = 1'b0;
      bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
      tick();
      tick();
      check("rst_valid1", 32'(bus.out1_valid), 32'd0);
      check("rst_valid2", 32'(bus.out2_valid), 32'd0);
      check("rst_data1", 32'(bus.out1_data), 32'h0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_perr", 32'(perr), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single word on ch1, latency one clock, valid for one cycle.
      bus.out1_ready = 1'b1;
      send_bits(1, frame(8'h05), FR);
      check("w05_valid", 32'(bus.out1_valid), 32'd1);
      check("w05_data", 32'(bus.out1_data), 32'h05);
      check("w05_v2", 32'(bus.out2_valid), 32'd0);
      tick();
      check("w05_drop", 32'(bus.out1_valid), 32'd0);

      // Overflow on ch2 with ready low: held word survives.
      bus.out2_ready = 1'b0;
      send_bits(2, frame(8'hA5), FR);
      check("a5_valid", 32'(bus.out2_valid), 32'd1);
      check("a5_data", 32'(bus.out2_data), 32'hA5);
      send_bits(2, frame(8'h3C), FR);
      check("ovf_data", 32'(bus.out2_data), 32'hA5);
      check("ovf_valid", 32'(bus.out2_valid), 32'd1);
      check("ovf_flag", 32'(ovf), 32'h2);
      bus.out2_ready = 1'b1;
      tick();
      check("a5_xfer", 32'(bus.out2_valid), 32'd0);
      bus.out2_ready = 1'b0;

      // Back-to-back: last bit of 8'h22 coincides with transfer of 8'h11.
      bus.out1_ready = 1'b0;
      send_bits(1, frame(8'h11), FR);
      f = frame(8'h22);
      send_bits(1, f, FR - 1);
      check("b2b_hold_data", 32'(bus.out1_data), 32'h11);
      check("b2b_hold_valid", 32'(bus.out1_valid), 32'd1);
      bus.out1_ready = 1'b1;
      send_bits(1, f >> (FR - 1), 1);
      check("b2b_data", 32'(bus.out1_data), 32'h22);
      check("b2b_valid", 32'(bus.out1_valid), 32'd1);
      check("b2b_ovf", 32'(ovf), 32'h2);
      tick();
      check("b2b_drop", 32'(bus.out1_valid), 32'd0);

      // Flush mid-frame, clr beats a coincident strobe.
      send_bits(1, 16'h000A, 4);
      clr = 1'b1;
      bus.in1_vld = 1'b1;
      bus.in1_bit = 1'b1;
      tick();
      clr = 1'b0;
      bus.in1_vld = 1'b0;
      f = frame(8'hFF);
      send_bits(1, f, FR - 1);
      check("clr_early", 32'(bus.out1_valid), 32'd0);
      send_bits(1, f >> (FR - 1), 1);
      check("clr_valid", 32'(bus.out1_valid), 32'd1);
      check("clr_data", 32'(bus.out1_data), 32'hFF);
      tick();

      // Reset mid-frame and with a pending ch2 word.
      send_bits(1, 16'h001F, 5);
      send_bits(2, frame(8'h5A), FR);
      check("pend_valid2", 32'(bus.out2_valid), 32'd1);
      rst_n = 1'b0;
      bus.out2_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      bus.out2_ready = 1'b0;
      check("mrst_valid1", 32'(bus.out1_valid), 32'd0);
      check("mrst_valid2", 32'(bus.out2_valid), 32'd0);
      check("mrst_data2", 32'(bus.out2_data), 32'h0);
      check("mrst_ovf", 32'(ovf), 32'd0);
      check("mrst_perr", 32'(perr), 32'd0);
      bus.out1_ready = 1'b1;
      f = frame(8'h96);
      send_bits(1, f, FR - 1);
      check("post_early", 32'(bus.out1_valid), 32'd0);
      send_bits(1, f >> (FR - 1), 1);
      check("post_valid", 32'(bus.out1_valid), 32'd1);
      check("post_data", 32'(bus.out1_data), 32'h96);
      tick();

`ifdef DMUX_DESER_PARITY_EN
      send_bits(1, 16'h0003, 9);
      check("par_ok_valid", 32'(bus.out1_valid), 32'd1);
      check("par_ok_data", 32'(bus.out1_data), 32'h03);
      check("par_ok_perr", 32'(perr), 32'd0);
      tick();
      send_bits(1, 16'h0103, 9);
      check("par_bad_valid", 32'(bus.out1_valid), 32'd0);
      check("par_bad_perr", 32'(perr), 32'h1);
      check("par_bad_ovf", 32'(ovf), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
